// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: configurable pattern and length, optional overlap, saturating match counter.
// Define PATDET_STICKY_EN to add the sticky_clr input and the found_sticky output.
module seq_pattern_detector #(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  output logic             found,
  output logic [CNT_W-1:0] match_cnt
`ifdef PATDET_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic             found_sticky
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               found_q, found_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_W-1:0]   hist_shift;
  logic [PAT_W-1:0]   mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamped;
  logic               beat;
  logic               window_full;
  logic               match;

  // The beat that brings fill up to len is already compared, so a match can complete on it.
  always_comb begin
    hist_shift  = (hist_q << 1) | {{(PAT_W-1){1'b0}}, in};
    fill_inc    = fill_q + 1'b1;
    len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
    mask        = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    beat        = in_valid && !cfg_we && (state_q != IDLE);
    window_full = (state_q == HUNT) || ((state_q == FILL) && (fill_inc >= len_q));
    match       = beat && window_full && ((hist_shift & mask) == (pat_q & mask));
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    found_d = match;
    cnt_d   = cnt_q;

    if (cfg_we) begin
      pat_d   = cfg_pattern;
      len_d   = len_clamped;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = (len_clamped == '0) ? IDLE : FILL;
    end else if (beat) begin
      hist_d = hist_shift;
      case (state_q)
        FILL: begin
          if (match && !ovl_q) begin
            fill_d = '0;
          end else if (fill_inc >= len_q) begin
            fill_d  = fill_inc;
            state_d = HUNT;
          end else begin
            fill_d = fill_inc;
          end
        end
        HUNT: begin
          if (match && !ovl_q) begin
            fill_d  = '0;
            state_d = FILL;
          end
        end
        default: state_d = state_q;
      endcase
    end

    // A clear that lands on a match still counts that match.
    if (clr_cnt) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      found_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
    end
  end

  assign found     = found_q;
  assign match_cnt = cnt_q;

`ifdef PATDET_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (match) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign found_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector (PAT_W=8, CNT_W=2): stimulus queues expected found pulses,
// a negedge monitor pops them whenever found is seen.
module tb_seq_pattern_detector;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in = 1'b0;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             found;
  logic [CNT_W-1:0] match_cnt;
`ifdef PATDET_STICKY_EN
  logic             sticky_clr = 1'b0;
  logic             found_sticky;
`endif

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cycle_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in          (in),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_cnt     (clr_cnt),
    .found       (found),
    .match_cnt   (match_cnt)
`ifdef PATDET_STICKY_EN
    ,
    .sticky_clr  (sticky_clr),
    .found_sticky(found_sticky)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Every found pulse must line up with a queued expectation (cycle and count).
  always @(negedge clk) begin
    if (found) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_found: found=1 at cycle %0d, required no pulse (match_cnt=%0d)",
                 cycle_cnt, match_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cycle_cnt || int'(match_cnt) != e.cnt) begin
          n_fail++;
          $display("[TB] FAIL found_pulse: got cycle %0d cnt %0d, required cycle %0d cnt %0d",
                   cycle_cnt, match_cnt, e.cyc, e.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic b, input logic we, input logic clr,
                               input logic exp_found, input int exp_cnt);
    @(negedge clk);
    in_valid = v;
    in       = b;
    cfg_we   = we;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
    if (exp_found) exp_q.push_back('{cyc: cycle_cnt, cnt: exp_cnt});
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic configure(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl, input logic with_beat);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    applyStimulus(with_beat, 1'b1, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic sendBits(input logic [31:0] bits, input int n, input int match_mask, input int cnt0);
    int cnt;
    cnt = cnt0;
    for (int i = n - 1; i >= 0; i--) begin
      logic hit;
      hit = match_mask[i];
      if (hit && cnt != 3) cnt++;
      applyStimulus(1'b1, bits[i], 1'b0, 1'b0, hit, cnt);
    end
  endtask

  task automatic clearCount();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("clr_cnt", int'(match_cnt), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_found", int'(found), 0);
    checkOutput("reset_cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unconfigured: beats are ignored.
    sendBits(32'b00110, 5, 0, 0);
    checkOutput("idle_cnt", int'(match_cnt), 0);

    // 00110, len 5, no overlap: one pulse after 5th beat.
    configure(8'b00110, 4'd5, 1'b0, 1'b0);
    sendBits(32'b00110, 5, 5'b00001, 0);
    idle(1);
    checkOutput("p00110_cnt", int'(match_cnt), 1);

    // 101 overlapping over 1,0,1,0,1: two pulses.
    clearCount();
    configure(8'b101, 4'd3, 1'b1, 1'b0);
    sendBits(32'b10101, 5, 5'b00101, 0);
    idle(1);
    checkOutput("ovl1_cnt", int'(match_cnt), 2);

    // Same stream without overlap: one pulse.
    clearCount();
    configure(8'b101, 4'd3, 1'b0, 1'b0);
    sendBits(32'b10101, 5, 5'b00100, 0);
    idle(1);
    checkOutput("ovl0_cnt", int'(match_cnt), 1);

    // Gap of 3 invalid cycles (with in=1) between beats 2 and 3.
    clearCount();
    configure(8'b00110, 4'd5, 1'b0, 1'b0);
    sendBits(32'b00, 2, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sendBits(32'b110, 3, 3'b001, 0);
    idle(1);
    checkOutput("gap_cnt", int'(match_cnt), 1);

    // Saturation: five overlapping matches -> 1,2,3,3,3, then clear on a 6th match -> 1.
    clearCount();
    configure(8'b101, 4'd3, 1'b1, 1'b0);
    sendBits(32'b10101010101, 11, 11'b00101010101, 0);
    checkOutput("sat_cnt", int'(match_cnt), 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    idle(1);
    checkOutput("clr_on_match_cnt", int'(match_cnt), 1);

    // Beat coinciding with cfg_we is discarded.
    clearCount();
    configure(8'b101, 4'd3, 1'b1, 1'b1);
    sendBits(32'b0101, 4, 4'b0001, 0);
    idle(1);
    checkOutput("cfg_discard_cnt", int'(match_cnt), 1);

    // Pattern bits above len ignored.
    clearCount();
    configure(8'hFD, 4'd3, 1'b0, 1'b0);
    sendBits(32'b101, 3, 3'b001, 0);
    idle(1);
    checkOutput("upper_bits_cnt", int'(match_cnt), 1);

    // len 0 -> IDLE; beats ignored.
    clearCount();
    configure(8'b101, 4'd0, 1'b1, 1'b0);
    sendBits(32'b101101, 6, 0, 0);
    checkOutput("len0_cnt", int'(match_cnt), 0);

    // len 15 clamps to 8.
    configure(8'hA5, 4'd15, 1'b0, 1'b0);
    sendBits(32'hA5, 8, 8'h01, 0);
    idle(1);
    checkOutput("clamp_cnt", int'(match_cnt), 1);

    // Reset after 4 beats of 00110, then the 5th bit: no found, count cleared, stays idle.
    configure(8'b00110, 4'd5, 1'b0, 1'b0);
    sendBits(32'b0011, 4, 0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_cnt", int'(match_cnt), 0);
    checkOutput("midreset_found", int'(found), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sendBits(32'b0, 1, 0, 0);
    sendBits(32'b00110, 5, 0, 0);
    idle(1);
    checkOutput("postreset_cnt", int'(match_cnt), 0);

`ifdef PATDET_STICKY_EN
    configure(8'b101, 4'd3, 1'b1, 1'b0);
    sendBits(32'b101, 3, 3'b001, 0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      checkOutput("sticky_hold", int'(found_sticky), 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    sticky_clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    sticky_clr = 1'b0;
    checkOutput("sticky_set_wins", int'(found_sticky), 1);
    sticky_clr = 1'b1;
    idle(1);
    sticky_clr = 1'b0;
    checkOutput("sticky_cleared", int'(found_sticky), 0);
`endif

    idle(3);
    checkOutput("pending_found", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 8, maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 16, match counter width.
REQ-003 SHALL have localparam LEN_W = $clog2(PAT_W)+1, the width of cfg_len.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  qualifies in; a beat is a cycle with in_valid=1.
REQ-007 in  input  1  serial data bit.
REQ-008 cfg_we  input  1  load cfg_pattern, cfg_len and cfg_overlap this cycle.
REQ-009 cfg_pattern  input  PAT_W  pattern; bit cfg_len-1 is received first, bit 0 last.
REQ-010 cfg_len  input  LEN_W  active pattern length.
REQ-011 cfg_overlap  input  1  1 = overlapping matches allowed, 0 = restart after a match.
REQ-012 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-013 found  output  1  registered one-cycle pulse per match.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-015 SHALL implement FSM states IDLE (unconfigured), FILL (fewer than len beats collected) and HUNT (comparing on every beat).
REQ-016 SHALL keep a PAT_W-bit history register: on each beat, shift left and insert in at bit 0; non-beat cycles hold all state.
REQ-017 SHALL keep a fill counter: increment per beat in FILL, move to HUNT once fill reaches len.
REQ-018 On a HUNT beat, SHALL detect a match when the newest len history bits, including the current bit, equal cfg_pattern[len-1:0]; bits above len are ignored.
REQ-019 found SHALL assert on the cycle after the completing beat, for exactly one cycle.
REQ-020 On a match with overlap=1, the FSM SHALL stay in HUNT.
REQ-021 On a match with overlap=0, the FSM SHALL clear fill and return to FILL.
REQ-022 cfg_we in any state SHALL latch the configuration, clear history and fill, and enter FILL.
REQ-023 When cfg_we and a beat coincide, the beat SHALL be discarded and found SHALL NOT assert from it.
REQ-024 cfg_len = 0 SHALL send the FSM to IDLE; cfg_len > PAT_W SHALL be clamped to PAT_W.
REQ-025 In IDLE, beats SHALL be ignored and found SHALL remain 0.
REQ-026 match_cnt SHALL increment per match and saturate at all-ones.
REQ-027 clr_cnt SHALL clear match_cnt; if clr_cnt coincides with a match, match_cnt SHALL become 1.
REQ-028 cfg_we SHALL NOT affect match_cnt.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, history 0, fill 0, pattern 0, len 0, overlap 0, found 0, match_cnt 0 (found_sticky 0 if present).
REQ-030 Reset applied mid-stream SHALL discard partial matches; after release, no found until reconfigured via cfg_we.

Configuration
REQ-031 With macro PATDET_STICKY_EN defined, the block SHALL add input sticky_clr (1 bit) and output found_sticky (1 bit).
REQ-032 found_sticky SHALL set on the cycle found asserts and hold until sticky_clr; if set and clear coincide, set SHALL win.
REQ-033 Without PATDET_STICKY_EN, the sticky_clr and found_sticky ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Load pattern 5'b00110, len 5, overlap 0; beats 0,0,1,1,0 -> found pulses once, one cycle after the 5th beat; match_cnt=1.
REQ-035 Pattern 3'b101, len 3: stream 1,0,1,0,1 with overlap=1 -> 2 found pulses, match_cnt=2; same stream with overlap=0 -> 1 pulse, match_cnt=1.
REQ-036 Pattern 00110 with in_valid deasserted for 3 cycles between beats 2 and 3 -> single found after the 5th beat; the gap breaks nothing.
REQ-037 CNT_W=2: drive 5 matches -> match_cnt 1,2,3,3,3; clr_cnt coinciding with the 6th match -> match_cnt=1.
REQ-038 rst_n low after 4 beats of 00110, release, then the 5th bit 0 -> no found, match_cnt=0, state IDLE.
REQ-039 With PATDET_STICKY_EN: one match -> found_sticky=1 held for 10 cycles; sticky_clr with a simultaneous match -> found_sticky stays 1.
